// File: rtl/bp_fe_controller_mt_pkg.sv
// Shared types for the multithreaded frontend controller: command classes,
// per-thread FSM states and small decode helpers.
package bp_fe_controller_mt_pkg;

  typedef enum logic [2:0] {
    e_cmd_reset    = 3'd0,
    e_cmd_redirect = 3'd1,
    e_cmd_wait     = 3'd2,
    e_cmd_fence    = 3'd3,
    e_cmd_complex  = 3'd4,
    e_cmd_attaboy  = 3'd5
  } bp_fe_cmd_class_e;

  typedef enum logic [1:0] {
    e_reset  = 2'd0,
    e_wait   = 2'd1,
    e_run    = 2'd2,
    e_resume = 2'd3
  } bp_fe_thread_state_e;

  localparam int cmd_class_width_gp    = 3;
  localparam int thread_state_width_gp = 2;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A thread leaving e_resume always goes back to running, whatever the command.
  function automatic bp_fe_thread_state_e cmd_next_state(input bp_fe_cmd_class_e    cls,
                                                         input bp_fe_thread_state_e cur);
    bp_fe_thread_state_e nxt;
    case (cls)
      e_cmd_wait, e_cmd_fence: nxt = e_wait;
      e_cmd_redirect:          nxt = e_run;
      default:                 nxt = e_resume;
    endcase
    if (cur == e_resume) nxt = e_run;
    return nxt;
  endfunction

  function automatic logic is_force_class(input bp_fe_cmd_class_e cls);
    return (cls == e_cmd_redirect) || (cls == e_cmd_wait) || (cls == e_cmd_fence);
  endfunction

endpackage

// File: rtl/bp_fe_controller_mt_if.sv
// I$/ITLB fetch-pipe handshake between the frontend controller (master) and
// the instruction cache (slave), including TL/TV thread tracking and poison.
interface bp_fe_controller_mt_if #(parameter int tid_width_p = 1);

  logic                   icache_v;
  logic                   icache_force;
  logic [tid_width_p-1:0] icache_tid;
  logic                   icache_yumi;
  logic                   tv_we;
  logic [tid_width_p-1:0] tl_tid;
  logic [tid_width_p-1:0] tv_tid;
  logic                   if2_exception;
  logic                   poison_tl;
  logic                   poison_tv;
  logic                   fetch_ready_then;

  modport master (
    output icache_v, icache_force, icache_tid, tl_tid, tv_tid,
           poison_tl, poison_tv, fetch_ready_then,
    input  icache_yumi, tv_we, if2_exception
  );

  modport slave (
    input  icache_v, icache_force, icache_tid, tl_tid, tv_tid,
           poison_tl, poison_tv, fetch_ready_then,
    output icache_yumi, tv_we, if2_exception
  );

endinterface

// File: rtl/bp_fe_controller_mt_arb.sv
// Combinational round-robin arbiter: searches requesters starting one past
// the last granted thread.
module bp_fe_controller_mt_arb
  import bp_fe_controller_mt_pkg::*;
  #(parameter  int threads_p    = 2
  , localparam int tid_width_lp = safe_clog2(threads_p))
  (input  logic [threads_p-1:0]    req_i
  , input  logic [tid_width_lp-1:0] last_i
  , output logic                    grant_v_o
  , output logic [tid_width_lp-1:0] grant_tid_o
  );

  always_comb begin
    logic                    found;
    logic [tid_width_lp-1:0] idx;
    found       = 1'b0;
    idx         = '0;
    grant_tid_o = '0;
    for (int i = 1; i <= threads_p; i++) begin
      idx = tid_width_lp'((int'(last_i) + i) % threads_p);
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        grant_tid_o = idx;
      end
    end
    grant_v_o = found;
  end

endmodule

// File: rtl/bp_fe_controller_mt.sv
// Multithreaded frontend controller: per-thread FE FSMs sharing one I$ fetch
// pipe, command-over-fetch arbitration and thread-selective TL/TV poisoning.
module bp_fe_controller_mt
  import bp_fe_controller_mt_pkg::*;
  #(parameter  int threads_p    = 2
  , localparam int tid_width_lp = safe_clog2(threads_p))
  (input  logic                                       clk_i
  , input  logic                                       reset_i
  , input  logic                                       pc_gen_init_done_i
  , input  logic [threads_p-1:0]                       cmd_v_i
  , input  logic [threads_p*cmd_class_width_gp-1:0]    cmd_class_i
  , output logic [threads_p-1:0]                       cmd_yumi_o
  , input  logic [threads_p-1:0]                       attaboy_yumi_i
  , input  logic [threads_p-1:0]                       fe_queue_ready_and_i
  , bp_fe_controller_mt_if.master                      icache_io
  , output logic                                       redirect_v_o
  , output logic [tid_width_lp-1:0]                    redirect_tid_o
  , output logic [threads_p*thread_state_width_gp-1:0] state_o
  );

  typedef logic [tid_width_lp-1:0] tid_t;

  logic [threads_p-1:0] cmd_live, cmd_cand, fetch_cand, force_cand, is_grant, is_tv;
  tid_t rr_q, rr_d, tl_tid_q, tl_tid_d, tv_tid_q, tv_tid_d;
  tid_t cmd_tid, fetch_tid, grant_tid;
  logic cmd_grant_v, fetch_grant_v, cmd_accept, force_v, fetch_ready_then, exc_v;

  for (genvar t = 0; t < threads_p; t++) begin : g_thread
    bp_fe_thread_state_e state_q, state_d;
    bp_fe_cmd_class_e    cls;
    logic                yumi;

    assign cls           = bp_fe_cmd_class_e'(cmd_class_i[cmd_class_width_gp*t +: cmd_class_width_gp]);
    assign cmd_live[t]   = cmd_v_i[t] & (cls != e_cmd_attaboy);
    assign cmd_cand[t]   = cmd_live[t] & (state_q != e_reset);
    assign fetch_cand[t] = (state_q == e_run) & fe_queue_ready_and_i[t] & ~cmd_live[t];
    assign force_cand[t] = is_force_class(cls) & (state_q != e_resume);
    assign is_grant[t]   = (grant_tid == tid_t'(t));
    assign is_tv[t]      = (tv_tid_q == tid_t'(t));

    always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= e_reset;
      else         state_q <= state_d;
    end

    // The command accept is evaluated last so it overrides a fetch exception.
    always_comb begin
      state_d = state_q;
      yumi    = 1'b0;
      if (state_q == e_reset) begin
        if (cmd_v_i[t] && (cls != e_cmd_reset)) begin
          yumi = 1'b1;
        end else if (cmd_v_i[t] && pc_gen_init_done_i) begin
          yumi    = 1'b1;
          state_d = e_resume;
        end
      end else begin
        if (cmd_v_i[t] && (cls == e_cmd_attaboy)) yumi = attaboy_yumi_i[t];
        if (exc_v && is_tv[t]) state_d = e_wait;
        if (cmd_accept && is_grant[t]) begin
          yumi    = 1'b1;
          state_d = cmd_next_state(cls, state_q);
        end
      end
    end

    assign cmd_yumi_o[t] = yumi;
    assign state_o[thread_state_width_gp*t +: thread_state_width_gp] = state_q;
  end

  bp_fe_controller_mt_arb #(.threads_p(threads_p)) cmd_arb (
    .req_i       (cmd_cand),
    .last_i      (rr_q),
    .grant_v_o   (cmd_grant_v),
    .grant_tid_o (cmd_tid)
  );

  bp_fe_controller_mt_arb #(.threads_p(threads_p)) fetch_arb (
    .req_i       (fetch_cand),
    .last_i      (rr_q),
    .grant_v_o   (fetch_grant_v),
    .grant_tid_o (fetch_tid)
  );

  assign grant_tid        = cmd_grant_v ? cmd_tid : fetch_tid;
  assign cmd_accept       = icache_io.icache_yumi & cmd_grant_v;
  assign force_v          = cmd_grant_v & |(force_cand & is_grant);
  assign fetch_ready_then = |(fetch_cand & is_tv);
  assign exc_v            = fetch_ready_then & icache_io.if2_exception;

  assign icache_io.icache_v         = cmd_grant_v | fetch_grant_v;
  assign icache_io.icache_force     = force_v;
  assign icache_io.icache_tid       = grant_tid;
  assign icache_io.tl_tid           = tl_tid_q;
  assign icache_io.tv_tid           = tv_tid_q;
  assign icache_io.fetch_ready_then = fetch_ready_then;
  // Only stages holding the affected thread are killed; a forced request
  // replaces TL anyway, so the exception need not poison it.
  assign icache_io.poison_tv = exc_v | (cmd_accept & (tv_tid_q == grant_tid));
  assign icache_io.poison_tl = (exc_v & (tl_tid_q == tv_tid_q) & ~force_v)
                             | (cmd_accept & (tl_tid_q == grant_tid));

  assign redirect_v_o   = cmd_accept;
  assign redirect_tid_o = cmd_accept ? grant_tid : '0;

  always_comb begin
    rr_d     = rr_q;
    tl_tid_d = tl_tid_q;
    tv_tid_d = tv_tid_q;
    if (icache_io.icache_yumi) begin
      rr_d     = grant_tid;
      tl_tid_d = grant_tid;
    end
    if (icache_io.tv_we) tv_tid_d = tl_tid_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      tl_tid_q <= '0;
      tv_tid_q <= '0;
    end else begin
      rr_q     <= rr_d;
      tl_tid_q <= tl_tid_d;
      tv_tid_q <= tv_tid_d;
    end
  end

endmodule
